delay_btn_ctrl: RTL and testbench

Front-end controller that turns the two raw blinker push-buttons into the single-cycle `faster` / `slower` step requests consumed by the blink-delay register. It synchronises and debounces both buttons and arbitrates between them so that at most one request fires per cycle. On a sustained press it issues one step immediately, then auto-repeats after a hold interval. It sits between the board button pins and the delay register, in the `clk` domain.

---
 rtl/delay_btn_ctrl.sv | 126 ++++++++++++
 tb/tb_delay_btn_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_btn_ctrl.sv
// Blinker button front end: synchronise, debounce, arbitrate and auto-repeat into faster/slower step pulses.
// First pulse DEBOUNCE_CYCLES+2 cycles after the press is captured, then HOLD_CYCLES, then every REPEAT_CYCLES.
module delay_btn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_faster_n,
  input  logic btn_slower_n,
  output logic faster,
  output logic slower,
  output logic repeating
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] HOLD     = 2'd1;
  localparam logic [1:0] REPEAT   = 2'd2;
  localparam logic [1:0] WAIT_REL = 2'd3;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REPEAT_CYCLES - 1);

  // Index 0 is the faster button, index 1 the slower button.
  logic [1:0]       sync1, sync2, deb;
  logic [CNT_W-1:0] deb_cnt [2];

  logic [1:0]       state, state_nxt;
  logic             dir, dir_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic             fire, fire_dir;
  logic             own_deb, other_deb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {btn_slower_n, btn_faster_n};
      sync2 <= sync1;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (~sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign own_deb   = dir ? deb[1] : deb[0];
  assign other_deb = dir ? deb[0] : deb[1];

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    timer_nxt = timer;
    fire      = 1'b0;
    fire_dir  = dir;
    case (state)
      IDLE: begin
        if (deb == 2'b11) begin
          state_nxt = WAIT_REL;
        end else if (deb != 2'b00) begin
          fire      = 1'b1;
          fire_dir  = deb[1];
          dir_nxt   = deb[1];
          timer_nxt = HOLD_LOAD;
          state_nxt = HOLD;
        end
      end
      HOLD, REPEAT: begin
        // Release beats a coinciding repeat expiry; a second button cancels the press.
        if (!own_deb) begin
          state_nxt = IDLE;
        end else if (other_deb) begin
          state_nxt = WAIT_REL;
        end else if (timer == '0) begin
          fire      = 1'b1;
          timer_nxt = REP_LOAD;
          state_nxt = REPEAT;
        end else begin
          timer_nxt = timer - CNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (deb == 2'b00) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      dir    <= 1'b0;
      timer  <= '0;
      faster <= 1'b0;
      slower <= 1'b0;
    end else begin
      state  <= state_nxt;
      dir    <= dir_nxt;
      timer  <= timer_nxt;
      faster <= fire & ~fire_dir;
      slower <= fire & fire_dir;
    end
  end

  assign repeating = (state == REPEAT);

endmodule

// File: tb/tb_delay_btn_ctrl.sv
// Directed bench for delay_btn_ctrl at default parameters; pulse times are offsets from the capture edge t0.
module tb_delay_btn_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  logic btn_faster_n;
  logic btn_slower_n;
  logic faster;
  logic slower;
  logic repeating;

  int checks = 0;
  int errors = 0;
  int f_times[$];
  int s_times[$];
  int rep_first;
  int both_hi = 0;

  always #5 clk = ~clk;

  delay_btn_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_faster_n (btn_faster_n),
    .btn_slower_n (btn_slower_n),
    .faster       (faster),
    .slower       (slower),
    .repeating    (repeating)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    f_times.delete();
    s_times.delete();
    rep_first = -1;
  endtask

  // Drive one cycle of button levels, then record what the outputs show after edge n.
  task automatic step(input logic fn, input logic sn, input int n);
    btn_faster_n = fn;
    btn_slower_n = sn;
    tick();
    if (faster === 1'b1) f_times.push_back(n);
    if (slower === 1'b1) s_times.push_back(n);
    if (faster === 1'b1 && slower === 1'b1) both_hi++;
    if (repeating === 1'b1 && rep_first < 0) rep_first = n;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn_faster_n = logic'(i & 1);
      btn_slower_n = logic'((i >> 1) & 1);
      tick();
      if ({faster, slower, repeating} !== 3'b000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_hold: %0d cycles with nonzero outputs, required 0", bad);
    end
    btn_faster_n = 1'b1;
    btn_slower_n = 1'b1;
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if ({faster, slower, repeating} !== 3'b000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_release_idle: %0d cycles with nonzero outputs, required 0", bad);
    end
  endtask

  task automatic test_short_press();
    int first;
    clear_rec();
    for (int n = 0; n < 80; n++) step(n < 40 ? 1'b0 : 1'b1, 1'b1, n);
    first = (f_times.size() > 0) ? f_times[0] : -1;
    checks++;
    if (f_times.size() !== 1) begin
      errors++;
      $display("FAIL short_count: faster pulses %0d, required 1", f_times.size());
    end
    checks++;
    if (first !== 18) begin
      errors++;
      $display("FAIL short_latency: first faster at t0+%0d, required t0+18", first);
    end
    checks++;
    if (s_times.size() !== 0) begin
      errors++;
      $display("FAIL short_no_slower: slower pulses %0d, required 0", s_times.size());
    end
    checks++;
    if (rep_first !== -1) begin
      errors++;
      $display("FAIL short_no_repeat: repeating seen at t0+%0d, required never", rep_first);
    end
  endtask

  task automatic test_bounce();
    clear_rec();
    for (int n = 0; n < 110; n++) step(1'b1, (n < 80 && (n % 16) != 15) ? 1'b0 : 1'b1, n);
    checks++;
    if (s_times.size() + f_times.size() !== 0) begin
      errors++;
      $display("FAIL bounce_reject: pulses %0d, required 0", s_times.size() + f_times.size());
    end
  endtask

  task automatic test_auto_repeat();
    int got, exp;
    clear_rec();
    for (int n = 0; n < 240; n++) step(1'b1, n < 200 ? 1'b0 : 1'b1, n);
    checks++;
    if (s_times.size() !== 10) begin
      errors++;
      $display("FAIL repeat_count: slower pulses %0d, required 10", s_times.size());
    end
    for (int i = 0; i < 10; i++) begin
      got = (i < s_times.size()) ? s_times[i] : -1;
      exp = (i == 0) ? 18 : 82 + 16 * (i - 1);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL repeat_pulse%0d: at t0+%0d, required t0+%0d", i, got, exp);
      end
    end
    checks++;
    if (rep_first !== 82) begin
      errors++;
      $display("FAIL repeat_flag_rise: at t0+%0d, required t0+82", rep_first);
    end
    checks++;
    if (repeating !== 1'b0) begin
      errors++;
      $display("FAIL repeat_flag_fall: repeating %b after release, required 0", repeating);
    end
    checks++;
    if (f_times.size() !== 0) begin
      errors++;
      $display("FAIL repeat_no_faster: faster pulses %0d, required 0", f_times.size());
    end
  endtask

  task automatic test_conflict_hold();
    int first;
    clear_rec();
    for (int n = 0; n < 190; n++)
      step(n < 100 ? 1'b0 : 1'b1, (n >= 30 && n < 130) ? 1'b0 : 1'b1, n);
    first = (f_times.size() > 0) ? f_times[0] : -1;
    checks++;
    if (f_times.size() !== 1 || first !== 18) begin
      errors++;
      $display("FAIL conflict_hold_faster: %0d pulses first at t0+%0d, required 1 at t0+18", f_times.size(), first);
    end
    checks++;
    if (s_times.size() !== 0) begin
      errors++;
      $display("FAIL conflict_hold_slower: slower pulses %0d, required 0", s_times.size());
    end
  endtask

  task automatic test_conflict_same();
    clear_rec();
    for (int n = 0; n < 110; n++) step(n < 60 ? 1'b0 : 1'b1, n < 60 ? 1'b0 : 1'b1, n);
    checks++;
    if (f_times.size() + s_times.size() !== 0) begin
      errors++;
      $display("FAIL conflict_same: pulses %0d, required 0", f_times.size() + s_times.size());
    end
  endtask

  task automatic test_mid_reset();
    int first;
    clear_rec();
    for (int n = 0; n < 99; n++) step(1'b1, 1'b0, n);
    checks++;
    if ({slower, repeating} !== 2'b11) begin
      errors++;
      $display("FAIL midreset_pre: slower,repeating %b, required 11", {slower, repeating});
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({faster, slower, repeating} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_async: outputs %b, required 000", {faster, slower, repeating});
    end
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b1;
    clear_rec();
    for (int n = 0; n < 70; n++) step(1'b1, n < 30 ? 1'b0 : 1'b1, n);
    first = (s_times.size() > 0) ? s_times[0] : -1;
    checks++;
    if (s_times.size() !== 1 || first !== 18) begin
      errors++;
      $display("FAIL midreset_after: %0d pulses first at t0+%0d, required 1 at t0+18", s_times.size(), first);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_hi !== 0) begin
      errors++;
      $display("FAIL exclusive: faster and slower high together in %0d cycles, required 0", both_hi);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    btn_faster_n = 1'b1;
    btn_slower_n = 1'b1;
    test_reset();
    test_short_press();
    test_bounce();
    test_auto_repeat();
    test_conflict_hold();
    test_conflict_same();
    test_mid_reset();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
